// File: rtl/systolic_pkg.sv
// Shared types and default dimensions for the systolic array datapath blocks.
package systolic_pkg;

  localparam int ARRAY_SIZE_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int LANE_DEPTH_DEF = 8;

  typedef logic signed [ACC_WIDTH_DEF-1:0] acc_t;

  // Index of the next row within a tile, wrapping at the array size.
  function automatic int unsigned next_row(input int unsigned cur, input int unsigned size);
    int unsigned nxt;
    if (cur == size - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = cur + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/deskew_lane_fifo.sv
// Single-lane FIFO of the deskew buffer: wrapping pointers, occupancy count and a drop strobe
// for writes that hit a full lane without a concurrent pop.
module deskew_lane_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign empty = (count_r == CNT_ZERO);
  assign full  = (count_r == CNT_FULL);
  assign head  = mem_r[rd_ptr_r];

  // A pop in the same edge frees the slot, so a full lane may still accept a write.
  always_comb begin
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    drop    = 1'b0;
    if (clr) begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
      drop    = 1'b0;
    end else begin
      rd_en_s = pop && !empty;
      wr_en_s = push && (!full || rd_en_s);
      drop    = push && full && !rd_en_s;
    end
  end

  // Storage array; contents need no clear since empty lanes are never observed.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/deskew_buffer.sv
// Re-aligns column-staggered accumulator results from the systolic array into full rows,
// one FIFO per lane, with valid/ready backpressure toward writeback.
module deskew_buffer
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LANE_DEPTH = LANE_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [ARRAY_SIZE-1:0]       in_valid,
  input  logic signed [ACC_WIDTH-1:0] data_in [ARRAY_SIZE],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] data_out [ARRAY_SIZE],
  output logic [$clog2(ARRAY_SIZE)-1:0] out_row_idx,
  output logic                        out_last,
  output logic                        overflow
);

  localparam int IDX_W = $clog2(ARRAY_SIZE);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ARRAY_SIZE - 1);

  logic                 clr_s;
  logic                 pop_s;
  logic [ARRAY_SIZE-1:0] empty_s;
  logic [ARRAY_SIZE-1:0] full_s;
  logic [ARRAY_SIZE-1:0] drop_s;
  logic [ACC_WIDTH-1:0] head_s [ARRAY_SIZE];
  logic [IDX_W-1:0]     row_idx_r;
  logic [IDX_W-1:0]     row_idx_next_s;
  logic                 overflow_r;
  logic                 unused_full_s;

  assign clr_s     = rst | flush;
  assign out_valid = &(~empty_s);
  assign pop_s     = out_valid && out_ready;

  // Lane fullness is handled inside each lane; it is not needed at this level.
  assign unused_full_s = &full_s;

  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
    deskew_lane_fifo #(
      .WIDTH (ACC_WIDTH),
      .DEPTH (LANE_DEPTH)
    ) u_lane (
      .clk     (clk),
      .clr     (clr_s),
      .push    (in_valid[j]),
      .pop     (pop_s),
      .data_in (data_in[j]),
      .head    (head_s[j]),
      .empty   (empty_s[j]),
      .full    (full_s[j]),
      .drop    (drop_s[j])
    );
  end

  // Rows are only presented when every lane has an entry; otherwise drive zeros.
  always_comb begin
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      if (out_valid) begin
        data_out[j] = head_s[j];
      end else begin
        data_out[j] = {ACC_WIDTH{1'b0}};
      end
    end
  end

  // Row index advance on each accepted row.
  always_comb begin
    row_idx_next_s = row_idx_r;
    if (pop_s) begin
      row_idx_next_s = IDX_W'(next_row(32'(row_idx_r), ARRAY_SIZE));
    end else begin
      row_idx_next_s = row_idx_r;
    end
  end

  // Row index register.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      row_idx_r <= IDX_ZERO;
    end else begin
      row_idx_r <= row_idx_next_s;
    end
  end

  // Sticky overflow, set by any lane dropping a write.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      overflow_r <= 1'b0;
    end else if (|drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign out_row_idx = row_idx_r;
  assign out_last    = out_valid && (row_idx_r == IDX_LAST);
  assign overflow    = overflow_r;

endmodule
